// File: rtl/ccff_cfg_loader.sv
// ccff_cfg_loader: configuration-chain loader for a routing tile.
// A serial bitstream is shifted through a NUM_BITS-deep chain and committed
// atomically to a shadow bank that drives the tile's mux selects, so those
// selects never move while the chain is shifting. ccff_tail feeds the next
// tile's ccff_head.
module ccff_cfg_loader #(
  parameter int NUM_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                shift_en,
  input  logic                ccff_head,
  output logic                ccff_tail,
  output logic [NUM_BITS-1:0] mem_out,
  output logic [NUM_BITS-1:0] mem_outb,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CNT_W = $clog2(NUM_BITS + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]          state;
  logic [CNT_W-1:0]    count;
  logic [NUM_BITS-1:0] chain;

  // Sequence control: IDLE waits for start, SHIFT counts bits, COMMIT lasts one cycle.
  // NOTE: every register here uses <= so all flops sample the same pre-edge values;
  // a blocking assignment would let later statements see the updated state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            count <= '0;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            count <= count + CNT_W'(1);
            if (count == CNT_W'(NUM_BITS - 1)) state <= COMMIT;
          end
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Shift chain: only moves while loading; holds its contents between loads.
  // NOTE: the chain is a plain register bank, not a RAM, so clearing it on reset
  // is cheap and keeps ccff_tail defined from the first cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else if (state == SHIFT && shift_en) begin
      chain <= {chain[NUM_BITS-2:0], ccff_head};
    end
  end

  // Shadow bank: updated only on the COMMIT exit edge so selects stay glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_out <= '0;
    end else if (state == COMMIT) begin
      mem_out <= chain;
    end
  end

  // Sticky protocol-violation flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (shift_en)          err <= 1'b1;
        SHIFT:   if (start)             err <= 1'b1;
        COMMIT:  if (start || shift_en) err <= 1'b1;
        default: err <= err;
      endcase
    end
  end

  // Status and complement outputs decode registered state, so they are glitch-free.
  // NOTE: mem_outb is derived rather than stored, so it can never disagree with mem_out.
  always_comb begin
    mem_outb  = ~mem_out;
    ccff_tail = chain[NUM_BITS-1];
    busy      = (state != IDLE);
    done      = (state == COMMIT);
  end

endmodule

// File: tb/tb_ccff_cfg_loader.sv
// Self-checking bench for ccff_cfg_loader. Two instances (4-bit and 16-bit
// chains) run in lockstep on one clock; a behavioural model per instance
// predicts every output after every edge.
module tb_ccff_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0 drives the 4-bit instance, index 1 the 16-bit instance.
  logic reset_s [2];
  logic start_s [2];
  logic shift_s [2];
  logic head_s  [2];

  logic        tail4, busy4, done4, err4;
  logic [3:0]  mo4, mob4;
  logic        tail16, busy16, done16, err16;
  logic [15:0] mo16, mob16;

  ccff_cfg_loader #(.NUM_BITS(4)) dut4 (
    .clk(clk), .reset(reset_s[0]), .start(start_s[0]), .shift_en(shift_s[0]),
    .ccff_head(head_s[0]), .ccff_tail(tail4), .mem_out(mo4), .mem_outb(mob4),
    .busy(busy4), .done(done4), .err(err4)
  );

  ccff_cfg_loader #(.NUM_BITS(16)) dut16 (
    .clk(clk), .reset(reset_s[1]), .start(start_s[1]), .shift_en(shift_s[1]),
    .ccff_head(head_s[1]), .ccff_tail(tail16), .mem_out(mo16), .mem_outb(mob16),
    .busy(busy16), .done(done16), .err(err16)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: the load is a phase (idle / loading / committing),
  // the chain is the last n bits shifted in, taken as a number.
  typedef enum {M_IDLE, M_LOAD, M_COMMIT} mode_t;
  mode_t       m_mode  [2];
  int          m_shift [2];
  int unsigned m_chain [2];
  int unsigned m_mem   [2];
  bit          m_err   [2];

  function automatic int width_of(input int id);
    return (id == 0) ? 4 : 16;
  endfunction

  function automatic int unsigned mask_of(input int id);
    return (32'd1 << width_of(id)) - 1;
  endfunction

  task automatic model_step(input int id);
    if (reset_s[id]) begin
      m_mode[id] = M_IDLE; m_shift[id] = 0; m_chain[id] = 0; m_mem[id] = 0; m_err[id] = 0;
    end else begin
      case (m_mode[id])
        M_IDLE: begin
          if (shift_s[id]) m_err[id] = 1;
          if (start_s[id]) begin m_mode[id] = M_LOAD; m_shift[id] = 0; end
        end
        M_LOAD: begin
          if (start_s[id]) m_err[id] = 1;
          if (shift_s[id]) begin
            m_chain[id] = ((m_chain[id] * 2) + (head_s[id] ? 1 : 0)) & mask_of(id);
            m_shift[id]++;
            if (m_shift[id] == width_of(id)) m_mode[id] = M_COMMIT;
          end
        end
        default: begin
          if (start_s[id] || shift_s[id]) m_err[id] = 1;
          m_mem[id]  = m_chain[id];
          m_mode[id] = M_IDLE;
        end
      endcase
    end
  endtask

  task automatic compare(input int id);
    logic [31:0] mo, mob, tl, bz, dn, er;
    string p;
    p = (id == 0) ? "n4" : "n16";
    if (id == 0) begin mo = 32'(mo4);  mob = 32'(mob4);  tl = 32'(tail4);  bz = 32'(busy4);  dn = 32'(done4);  er = 32'(err4);  end
    else         begin mo = 32'(mo16); mob = 32'(mob16); tl = 32'(tail16); bz = 32'(busy16); dn = 32'(done16); er = 32'(err16); end
    check({p, " mem_out"},   mo,  m_mem[id]);
    check({p, " mem_outb"},  mob, ~m_mem[id] & mask_of(id));
    check({p, " ccff_tail"}, tl,  (m_chain[id] >> (width_of(id) - 1)) & 1);
    check({p, " busy"},      bz,  32'(m_mode[id] != M_IDLE));
    check({p, " done"},      dn,  32'(m_mode[id] == M_COMMIT));
    check({p, " err"},       er,  32'(m_err[id]));
  endtask

  // One clock: both models step on the edge, outputs compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    for (int id = 0; id < 2; id++) model_step(id);
    #1;
    for (int id = 0; id < 2; id++) compare(id);
  endtask

  task automatic drive(input int id, input logic r, input logic s, input logic e, input logic h);
    reset_s[id] = r; start_s[id] = s; shift_s[id] = e; head_s[id] = h;
  endtask

  // Load a 4-bit word MSB first into the small instance with gap stall cycles between bits.
  task automatic load4(input logic [3:0] word, input int gap);
    drive(0, 0, 1, 0, 0); tick();
    for (int k = 3; k >= 0; k--) begin
      drive(0, 0, 0, 1, word[k]); tick();
      if (k != 0) for (int g = 0; g < gap; g++) begin drive(0, 0, 0, 0, 0); tick(); end
    end
    drive(0, 0, 0, 0, 0); tick();   // COMMIT cycle
  endtask

  initial begin
    logic [15:0] word;
    int bit_idx, cycles, busy_cnt, done_cnt, stalls;

    for (int id = 0; id < 2; id++) begin
      drive(id, 1, 0, 0, 0);
      m_mode[id] = M_IDLE; m_shift[id] = 0; m_chain[id] = 0; m_mem[id] = 0; m_err[id] = 0;
    end

    // 1: reset for two cycles
    tick(); tick();
    check("reset mem_out", 32'(mo4), 32'h0);
    check("reset mem_outb", 32'(mob4), 32'hf);
    drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    tick();

    // 2: back-to-back load of 1,0,1,1
    load4(4'b1011, 0);
    tick();
    check("load 1011", 32'(mo4), 32'hb);
    check("load 1011 b", 32'(mob4), 32'h4);

    // 3: stalled load of 0,1,1,0 with 2 idle cycles between bits
    load4(4'b0110, 2);
    tick();
    check("load 0110", 32'(mo4), 32'h6);

    // 4a: shift_en in IDLE -> chain unchanged, err set
    drive(0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 0); tick();
    check("idle shift err", 32'(err4), 32'h1);
    // 4b: start together with shift_en in IDLE, then load completes normally
    drive(0, 0, 1, 1, 1); tick();
    for (int k = 3; k >= 0; k--) begin drive(0, 0, (k == 2), 1, 4'b1001 >> k); tick(); end
    drive(0, 0, 0, 1, 0); tick();   // shift_en during COMMIT is a violation
    drive(0, 0, 0, 0, 0); tick();
    check("load 1001", 32'(mo4), 32'h9);
    // 4c: reset clears err; start mid-SHIFT alone sets it again
    drive(0, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 1); tick();
    drive(0, 0, 1, 1, 1); tick();
    drive(0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    check("mid-shift start err", 32'(err4), 32'h1);
    check("mid-shift load", 32'(mo4), 32'hc);

    // 5: reset after 2 of 4 shifts discards the load
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 1, 1); tick();
    drive(0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    check("abort busy", 32'(busy4), 32'h0);
    check("abort done", 32'(done4), 32'h0);
    check("abort mem", 32'(mo4), 32'h0);

    // 6: random 16-bit words with ~50% shift_en on the wide instance
    for (int rep = 0; rep < 4; rep++) begin
      word = 16'($urandom);
      busy_cnt = 0; done_cnt = 0; stalls = 0; bit_idx = 15; cycles = 0;
      drive(1, 0, 1, 0, 0); tick();
      busy_cnt += busy16;
      while (bit_idx >= 0 && cycles < 500) begin
        if ($urandom_range(1, 0) == 1) begin
          drive(1, 0, 0, 1, word[bit_idx]); bit_idx--;
        end else begin
          drive(1, 0, 0, 0, 1'($urandom)); stalls++;
        end
        tick(); cycles++;
        busy_cnt += busy16; done_cnt += done16;
      end
      check("rand bound", 32'(bit_idx < 0), 32'h1);
      drive(1, 0, 0, 0, 0); tick();
      busy_cnt += busy16; done_cnt += done16;
      check("rand word", 32'(mo16), 32'(word));
      check("rand done cnt", 32'(done_cnt), 32'h1);
      check("rand busy cnt", 32'(busy_cnt), 32'(16 + stalls + 1));
      check("rand err", 32'(err16), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
